// File: rtl/vita_align_pkg.sv
// Shared definitions for the VITA lane word aligner: state encoding,
// default training words and a constant clog2 for counter sizing.
package vita_align_pkg;

  localparam logic [5:0] S_IDLE   = 6'b000001;
  localparam logic [5:0] S_SETTLE = 6'b000010;
  localparam logic [5:0] S_CHECK  = 6'b000100;
  localparam logic [5:0] S_SLIP   = 6'b001000;
  localparam logic [5:0] S_LOCKED = 6'b010000;
  localparam logic [5:0] S_FAILED = 6'b100000;

  typedef enum logic [5:0] {
    ST_IDLE   = S_IDLE,
    ST_SETTLE = S_SETTLE,
    ST_CHECK  = S_CHECK,
    ST_SLIP   = S_SLIP,
    ST_LOCKED = S_LOCKED,
    ST_FAILED = S_FAILED
  } align_state_e;

  localparam logic [9:0] TRAIN_10B = 10'h3A6;
  localparam logic [7:0] TRAIN_8B  = 8'hE9;
  localparam logic [3:0] TRAIN_4B  = 4'h9;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bitslip_aligner.sv
// Per-lane word aligner: slips the upstream bitslip muxer until the
// parallel word matches the training pattern for MATCH_COUNT words.
module bitslip_aligner
  import vita_align_pkg::*;
#(
  parameter int unsigned DATAWIDTH     = 10,
  parameter logic [9:0]  TRAINING      = TRAIN_10B,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MATCH_COUNT   = 16,
  localparam int unsigned CW = clog2(DATAWIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] din,
  output logic                 bitslip,
  output logic                 busy,
  output logic                 locked,
  output logic                 failed,
  output logic [CW-1:0]        slip_count
);

  localparam int unsigned SW = clog2(SETTLE_CYCLES + 1);
  localparam int unsigned MW = clog2(MATCH_COUNT + 1);
  localparam logic [DATAWIDTH-1:0] TRAIN_W = TRAINING[DATAWIDTH-1:0];

  align_state_e   state_q;
  logic [SW-1:0]  settle_q;
  logic [MW-1:0]  match_q;
  logic [CW-1:0]  slip_q;
  logic           bitslip_q;
  logic           busy_q;
  logic           locked_q;
  logic           failed_q;

  // The start path settles one cycle longer than the post-slip path (reload
  // with SETTLE_CYCLES-1), since SLIP itself already spent one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      match_q   <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
      failed_q  <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_LOCKED, ST_FAILED: begin
          if (start) begin
            locked_q <= 1'b0;
            failed_q <= 1'b0;
            slip_q   <= '0;
            settle_q <= SW'(SETTLE_CYCLES);
            busy_q   <= 1'b1;
            state_q  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_q == '0) begin
            match_q <= '0;
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        ST_CHECK: begin
          if (din == TRAIN_W) begin
            if (match_q == MW'(MATCH_COUNT - 1)) begin
              locked_q <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= ST_LOCKED;
            end else begin
              match_q <= match_q + 1'b1;
            end
          end else if (slip_q == CW'(DATAWIDTH - 1)) begin
            failed_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_FAILED;
          end else begin
            bitslip_q <= 1'b1;
            slip_q    <= slip_q + 1'b1;
            state_q   <= ST_SLIP;
          end
        end
        ST_SLIP: begin
          settle_q <= SW'(SETTLE_CYCLES - 1);
          state_q  <= ST_SETTLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bitslip    = bitslip_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign failed     = failed_q;
  assign slip_count = slip_q;

endmodule

// File: tb/tb_bitslip_aligner.sv
// Directed bench for bitslip_aligner with a behavioural bitslip muxer as load.
module tb_bitslip_aligner;

  localparam int S = 4;
  localparam logic [9:0] TRN = 10'h3A6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       din_sel = 1'b0;
  logic [9:0] din_drv = TRN;
  logic [9:0] din;
  logic       bitslip, busy, locked, failed;
  logic [3:0] slip_count;

  logic [3:0] mux_pos;
  logic [9:0] mux_dout;
  logic [9:0] src_word;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulses = 0;
  int gap_err = 0;
  int consec_err = 0;
  int last_pulse = -1000;
  logic prev_slip = 1'b0;
  int p0;

  assign din = din_sel ? mux_dout : din_drv;

  bitslip_aligner #(
    .DATAWIDTH(10), .TRAINING(TRN), .SETTLE_CYCLES(S), .MATCH_COUNT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .bitslip(bitslip), .busy(busy), .locked(locked), .failed(failed),
    .slip_count(slip_count)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] rotr(input logic [9:0] x, input int k);
    logic [19:0] d;
    d = {x, x};
    d = d >> k;
    return d[9:0];
  endfunction

  // Muxer load: bitslip to dout latency of two edges.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      mux_pos  <= '0;
      mux_dout <= '0;
    end else begin
      if (bitslip) mux_pos <= (mux_pos == 4'd9) ? 4'd0 : mux_pos + 4'd1;
      mux_dout <= rotr(src_word, int'(mux_pos));
    end
  end

  always @(negedge clk) begin
    if (bitslip) begin
      pulses = pulses + 1;
      if (prev_slip) consec_err = consec_err + 1;
      if (cyc - last_pulse < S + 1) gap_err = gap_err + 1;
      last_pulse = cyc;
    end
    prev_slip = bitslip;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) @(negedge clk);
    chk("tmo_busy", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    src_word = rotr(TRN, 7);
    repeat (3) @(negedge clk);
    chk("rst_bitslip", bitslip, 0);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_failed", failed, 0);
    chk("rst_slips", slip_count, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Already aligned: lock exactly 1+S+16 edges after the start edge.
    p0 = pulses;
    pulse_start();
    chk("al_busy", busy, 1);
    repeat (20) @(negedge clk);
    chk("al_lock_early", locked, 0);
    @(negedge clk);
    chk("al_locked", locked, 1);
    chk("al_busy_done", busy, 0);
    chk("al_slips", slip_count, 0);
    chk("al_failed", failed, 0);
    chk("al_pulses", pulses - p0, 0);

    // Restart from LOCKED clears locked right away.
    pulse_start();
    chk("rs_locked_clr", locked, 0);
    chk("rs_busy", busy, 1);
    wait_idle(100);
    chk("rs_relock", locked, 1);

    // 15 matches then a bad word: slip once, then a full fresh run.
    p0 = pulses;
    pulse_start();
    repeat (20) @(negedge clk);
    din_drv = 10'h000;
    @(negedge clk);
    din_drv = TRN;
    chk("pm_bitslip", bitslip, 1);
    chk("pm_locked", locked, 0);
    repeat (20) @(negedge clk);
    chk("pm_lock_early", locked, 0);
    @(negedge clk);
    chk("pm_locked2", locked, 1);
    chk("pm_slips", slip_count, 1);
    chk("pm_pulses", pulses - p0, 1);

    // Never matches: nine slips then failed.
    din_drv = 10'h000;
    p0 = pulses;
    pulse_start();
    wait_idle(300);
    chk("fl_failed", failed, 1);
    chk("fl_locked", locked, 0);
    chk("fl_slips", slip_count, 9);
    chk("fl_pulses", pulses - p0, 9);
    repeat (20) @(negedge clk);
    chk("fl_quiet", pulses - p0, 9);

    // start during SETTLE is ignored; reset mid-SETTLE clears everything.
    pulse_start();
    for (int i = 0; i < 50 && !bitslip; i++) @(negedge clk);
    chk("ig_saw_slip", bitslip, 1);
    @(negedge clk);
    pulse_start();
    chk("ig_slips", slip_count, 1);
    chk("ig_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_bitslip", bitslip, 0);
    chk("mr_slips", slip_count, 0);
    chk("mr_failed", failed, 0);

    // Through the muxer model with three bits of misalignment.
    din_sel = 1'b1;
    repeat (4) @(negedge clk);
    p0 = pulses;
    pulse_start();
    wait_idle(300);
    chk("mx_locked", locked, 1);
    chk("mx_slips", slip_count, 3);
    chk("mx_pulses", pulses - p0, 3);
    repeat (5) @(negedge clk);
    chk("mx_dout", mux_dout, TRN);
    chk("mx_gap", gap_err, 0);
    chk("mx_consec", consec_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
